// File: rtl/display_scan_ctrl.sv
// 8-digit 7-segment scan scheduler: blank gap + dwell per digit, frame-aligned value updates.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 always shown).
module display_scan_ctrl #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic        dbg_sel,
    input  logic [31:0] dbg_val,
    input  logic [7:0]  digit_en,
    output logic [7:0]  digitselect,
    output logic [3:0]  value4bit,
    output logic [31:0] shown_val,
    output logic        frame_done
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic {BLANK, DWELL} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    sel_nx;
    logic [3:0]    nib_nx;
    logic          fd_nx;
    logic          lz;
    logic          boundary;
    logic          xfer;
    logic [31:0]   pending;
    logic          pending_valid;

    assign wr_ready = ~pending_valid;
    assign xfer     = wr_valid & wr_ready;
    assign boundary = (state == DWELL) && (idx == 3'd7) && (cnt == DWELL_LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        case (state)
            BLANK: if (cnt == BLANK_LAST) begin
                state_nx = DWELL;
                cnt_nx   = '0;
            end
            DWELL: if (cnt == DWELL_LAST) begin
                state_nx = BLANK;
                cnt_nx   = '0;
                idx_nx   = idx + 3'd1;
            end
            default: begin
                state_nx = BLANK;
                cnt_nx   = '0;
            end
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        lz = (idx_nx != 3'd0) && ((shown_val >> {idx_nx, 2'b00}) == 32'd0);
`else
        lz = 1'b0;
`endif

        // Outputs are computed for the upcoming cycle so the first DWELL cycle already drives the digit.
        sel_nx = 8'hFF;
        nib_nx = 4'h0;
        if (state_nx == DWELL) begin
            nib_nx = shown_val[{idx_nx, 2'b00} +: 4];
            if (digit_en[idx_nx] && !lz)
                sel_nx = ~(8'b1 << idx_nx);
        end
        fd_nx = (state_nx == DWELL) && (idx_nx == 3'd7) && (cnt_nx == DWELL_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= '0;
            digitselect   <= 8'hFF;
            value4bit     <= 4'h0;
            frame_done    <= 1'b0;
            shown_val     <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            digitselect <= sel_nx;
            value4bit   <= nib_nx;
            frame_done  <= fd_nx;
            if (boundary) begin
                if (dbg_sel)
                    shown_val <= dbg_val;
                else if (pending_valid)
                    shown_val <= pending;
            end
            // A transfer can only happen while nothing is pending, so it never collides with consumption.
            if (xfer) begin
                pending       <= wr_data;
                pending_valid <= 1'b1;
            end else if (boundary && !dbg_sel) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a frame-position model (DWELL=4, BLANK=2, 48-clock frame).
module tb_display_scan_ctrl;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SLOT = DW + BL;
    localparam int FRAME = 8 * SLOT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        dbg_sel = 1'b0;
    logic [31:0] dbg_val = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic [7:0]  digitselect;
    logic [3:0]  value4bit;
    logic [31:0] shown_val;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Model state
    bit          model_ok = 1'b0;
    int          mt;
    logic [31:0] mshown, mpend;
    bit          mpv;
    logic [7:0]  m_sel;
    logic [3:0]  m_nib;
    bit          m_fd, m_dw;

    display_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val), .digit_en(digit_en),
        .digitselect(digitselect), .value4bit(value4bit),
        .shown_val(shown_val), .frame_done(frame_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: position within the frame decides everything about the scan.
    initial begin
        int cur, np, id;
        bit bnd, xfer, lz;
        forever begin
            @(posedge clock);
            if (reset) begin
                mt = 0; mshown = '0; mpend = '0; mpv = 1'b0;
                m_sel = 8'hFF; m_nib = 4'h0; m_fd = 1'b0; m_dw = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                cur  = mt;
                bnd  = (cur % FRAME) == FRAME - 1;
                xfer = wr_valid && !mpv;
                if (bnd) begin
                    if (dbg_sel) mshown = dbg_val;
                    else if (mpv) begin mshown = mpend; mpv = 1'b0; end
                end
                if (xfer) begin mpend = wr_data; mpv = 1'b1; end
                mt   = cur + 1;
                np   = mt % FRAME;
                id   = np / SLOT;
                m_dw = (np % SLOT) >= BL;
                m_fd = (np == FRAME - 1);
                m_nib = 4'((mshown >> (4 * id)) & 32'hF);
`ifdef LEADING_ZERO_BLANK_EN
                lz = (id > 0) && ((mshown >> (4 * id)) == 32'd0);
`else
                lz = 1'b0;
`endif
                m_sel = 8'hFF;
                if (m_dw && digit_en[id] && !lz) m_sel = ~(8'h01 << id);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (model_ok) begin
                chk("m_digitselect", {24'd0, digitselect}, {24'd0, m_sel});
                if (m_dw) chk("m_value4bit", {28'd0, value4bit}, {28'd0, m_nib});
                chk("m_shown_val", shown_val, mshown);
                chk("m_wr_ready", {31'd0, wr_ready}, {31'd0, !mpv});
                chk("m_frame_done", {31'd0, frame_done}, {31'd0, m_fd});
            end
        end
    end

    // Returns at the negedge inside the boundary cycle (frame position 47).
    task automatic wait_fd();
        bit found = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin found = 1'b1; break; end
        end
        chk("frame_done_wait", {31'd0, found}, 32'd1);
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clock);
        wr_valid = 1'b0;
        wr_data  = 32'h0BAD_0BAD;
    endtask

    initial begin
        logic [7:0] seq0 [12];
        logic [31:0] v1;
        int t0;
        seq0 = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                 8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
        v1 = 32'h89AB_CDEF;

        repeat (3) @(negedge clock);
        chk("reset_sel", {24'd0, digitselect}, 32'h0000_00FF);
        chk("reset_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset_shown", shown_val, 32'd0);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;

        // 1: scan order after reset
        for (int k = 0; k < 12; k++) begin
            chk("scan_seq", {24'd0, digitselect}, {24'd0, seq0[k]});
            @(negedge clock);
        end

        // 2: mid-frame write, visible only from the next frame
        write_word(v1);
        chk("wr_ready_low", {31'd0, wr_ready}, 32'd0);
        chk("shown_unchanged", shown_val, 32'd0);
        wait_fd();
        t0 = cyc;
        @(negedge clock);
        chk("shown_after_fd", shown_val, v1);
        for (int i = 0; i < 8; i++) begin
            repeat ((i == 0) ? 2 : SLOT) @(negedge clock);
            chk("nibble_seq", {28'd0, value4bit}, {28'd0, v1[4*i +: 4]});
        end
        chk("wr_ready_back", {31'd0, wr_ready}, 32'd1);

        // 3: debug source wins while a write stays pending
        dbg_sel = 1'b1;
        dbg_val = 32'hDEAD_BEEF;
        write_word(32'h1234_5678);
        wait_fd();
        chk("fd_period", cyc - t0, FRAME);
        @(negedge clock);
        chk("dbg_shown", shown_val, 32'hDEAD_BEEF);
        chk("dbg_ready_low", {31'd0, wr_ready}, 32'd0);
        dbg_sel = 1'b0;
        wait_fd();
        @(negedge clock);
        chk("pending_shown", shown_val, 32'h1234_5678);
        chk("pending_ready", {31'd0, wr_ready}, 32'd1);

        // 4: odd digits only, frame period unchanged
        digit_en = 8'b1010_1010;
        wait_fd();
        t0 = cyc;
        for (int p = 0; p < FRAME; p++) begin
            logic [7:0] e;
            @(negedge clock);
            e = 8'hFF;
            if ((p % SLOT) >= BL && ((p / SLOT) % 2) == 1) e = ~(8'h01 << (p / SLOT));
            if ((p % SLOT) == BL || p == FRAME - 1)
                chk("en_mask_sel", {24'd0, digitselect}, {24'd0, e});
        end
        chk("en_mask_fd", {31'd0, frame_done}, 32'd1);
        chk("en_mask_period", cyc - t0, FRAME);
        digit_en = 8'hFF;

        // 5: reset mid-dwell of digit 3 with a write pending
        repeat (5) @(negedge clock);
        write_word(32'h5555_5555);
        repeat (15) @(negedge clock);
        chk("pre_reset_sel", {24'd0, digitselect}, 32'h0000_00F7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_sel", {24'd0, digitselect}, 32'h0000_00FF);
        chk("rst_shown", shown_val, 32'd0);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        repeat (2) @(negedge clock);
        chk("rst_restart", {24'd0, digitselect}, 32'h0000_00FE);
        wait_fd();
        @(negedge clock);
        chk("rst_discard", shown_val, 32'd0);

        // 6: leading-zero behaviour
        write_word(32'h0000_00A0);
        wait_fd();
        repeat (3) @(negedge clock);
        chk("lz_d0_sel", {24'd0, digitselect}, 32'h0000_00FE);
        chk("lz_d0_nib", {28'd0, value4bit}, 32'd0);
        repeat (SLOT) @(negedge clock);
        chk("lz_d1_sel", {24'd0, digitselect}, 32'h0000_00FD);
        chk("lz_d1_nib", {28'd0, value4bit}, 32'h0000_000A);
        repeat (SLOT) @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d2_sel", {24'd0, digitselect}, 32'h0000_00FF);
`else
        chk("lz_d2_sel", {24'd0, digitselect}, 32'h0000_00FB);
`endif
        write_word(32'h0);
        wait_fd();
        repeat (3) @(negedge clock);
        chk("zero_d0_sel", {24'd0, digitselect}, 32'h0000_00FE);
        chk("zero_d0_nib", {28'd0, value4bit}, 32'd0);
        repeat (SLOT) @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        chk("zero_d1_sel", {24'd0, digitselect}, 32'h0000_00FF);
`else
        chk("zero_d1_sel", {24'd0, digitselect}, 32'h0000_00FD);
`endif
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Scan scheduler for the 8-digit 7-segment display on the MIPS/VGA board. Time-multiplexes one shared hexto7seg decoder across eight digits, with a programmable dwell per digit and an all-off blanking gap between digits to suppress ghosting. Arbitrates the displayed 32-bit value between a CPU write port (valid/ready) and a debug source. Updates the displayed value only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
DWELL_CYCLES, 100000, clocks each digit is driven on; must be >= 1
BLANK_CYCLES, 1000, clocks all digits are off before each dwell; must be >= 1

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
wr_valid  in  1  CPU offers wr_data
wr_ready  out  1  controller can accept wr_data
wr_data  in  32  value requested by the CPU
dbg_sel  in  1  1 = debug source wins at the frame boundary
dbg_val  in  32  debug value
digit_en  in  8  per-digit enable; bit i gates digit i
digitselect  out  8  active-low digit strobes; bit i = digit i
value4bit  out  4  nibble for the current digit; drives hexto7seg
shown_val  out  32  value currently being displayed (shadow register)
frame_done  out  1  one-cycle pulse at the end of each 8-digit frame

Behaviour:
- Reset values: state=BLANK, idx=0, cnt=0, digitselect=8'hFF, value4bit=0, shown_val=0, pending_valid=0, wr_ready=1, frame_done=0.
- Reset has priority over every other event, including mid-dwell and mid-handshake. An accepted-but-unconsumed write is discarded.
- FSM has two states.
  - BLANK: digitselect=8'hFF for BLANK_CYCLES clocks. When cnt==BLANK_CYCLES-1, go to DWELL and set cnt=0.
  - DWELL: lasts DWELL_CYCLES clocks. When cnt==DWELL_CYCLES-1, go to BLANK, set cnt=0 and idx=idx+1 mod 8.
- All outputs are registered. digitselect and value4bit take their DWELL values on the first DWELL cycle.
- DWELL outputs:
  - digitselect = ~(8'b1<<idx) if digit_en[idx]=1, else 8'hFF.
  - value4bit = shown_val[4*idx+3 : 4*idx]. Digit 7 uses bits [31:28].
- digit_en is sampled each cycle. A digit disabled mid-dwell goes dark on the next cycle.
- Slot timing is independent of digit_en, so the refresh rate is constant. Frame period is exactly 8*(BLANK_CYCLES+DWELL_CYCLES) clocks.
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready on a clock edge. wr_data is captured into pending, pending_valid is set, and wr_ready=0 from the next cycle.
  - wr_data may change freely when no transfer occurs.
- Frame boundary is the last DWELL cycle of idx=7.
  - frame_done=1 for that single cycle.
  - If dbg_sel=1 on that cycle: shown_val<=dbg_val, and pending is retained.
  - Else if pending_valid: shown_val<=pending, pending_valid<=0, and wr_ready=1 from the next cycle.
  - Else shown_val holds.
- The new shown_val first appears on idx=0 of the following frame.
- A write accepted on the boundary cycle itself waits for the next boundary. Pending is only ever sampled before that cycle's capture.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: during the DWELL of idx, the digit is forced off (digitselect=8'hFF) when idx>0 and shown_val[31:4*idx]==0. Digit 0 is always shown, so 0 displays as a single "0". Slot timing is unchanged.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
1. Bench uses DWELL_CYCLES=4, BLANK_CYCLES=2. Release reset -> digitselect=FF for 2 clocks, FE for 4, FF for 2, FD for 4, ... frame_done pulses every 48 clocks.
2. Write 32'h89ABCDEF mid-frame -> wr_ready falls the next cycle; the current frame is unchanged; after frame_done, value4bit sequence is F,E,D,C,B,A,9,8 and wr_ready=1.
3. Write 32'h12345678 then hold dbg_sel=1 with dbg_val=32'hDEADBEEF across a boundary -> shown_val=DEADBEEF and wr_ready stays 0; drop dbg_sel -> the next boundary gives shown_val=12345678.
4. digit_en=8'b1010_1010 -> digits 0,2,4,6 stay 8'hFF during their slots; the 48-clock frame period is unchanged.
5. Assert reset during the DWELL of idx=3 with a write pending -> next cycle digitselect=FF, shown_val=0, wr_ready=1, and scanning restarts at idx=0.
6. With LEADING_ZERO_BLANK_EN and shown_val=32'h0000_00A0 -> only digits 0 and 1 strobe (nibbles 0, A); with shown_val=0 -> only digit 0 strobes, showing 0.
